// File: rtl/ps2_keyboard.sv
module ps2_keyboard #(
  parameter int unsigned TIMEOUT = 25000,
  parameter int unsigned FILTER  = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       kdone,
  output logic [7:0] ascii
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned FW = $clog2(FILTER + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_filt;
  logic [FW-1:0] r_fcnt;
  logic          r_fall;
  state_t        r_state;
  logic [7:0]    r_shreg;
  logic [2:0]    r_bitcnt;
  logic [TW-1:0] r_timer;
  logic          r_shift;
  logic          r_brk;
  logic          r_ext;
`ifdef PS2_PARITY_EN
  logic          r_par;
`endif

  logic          w_dat;
  logic          w_par_ok;
  logic [7:0]    w_norm;
  logic [7:0]    w_extc;

  function automatic logic [7:0] norm_lookup(input logic [7:0] code, input logic shift);
    logic [7:0] r;
    r = 8'h00;
    case (code)
      8'h1C: r = 8'h61; 8'h32: r = 8'h62; 8'h21: r = 8'h63; 8'h23: r = 8'h64;
      8'h24: r = 8'h65; 8'h2B: r = 8'h66; 8'h34: r = 8'h67; 8'h33: r = 8'h68;
      8'h43: r = 8'h69; 8'h3B: r = 8'h6A; 8'h42: r = 8'h6B; 8'h4B: r = 8'h6C;
      8'h3A: r = 8'h6D; 8'h31: r = 8'h6E; 8'h44: r = 8'h6F; 8'h4D: r = 8'h70;
      8'h15: r = 8'h71; 8'h2D: r = 8'h72; 8'h1B: r = 8'h73; 8'h2C: r = 8'h74;
      8'h3C: r = 8'h75; 8'h2A: r = 8'h76; 8'h1D: r = 8'h77; 8'h22: r = 8'h78;
      8'h35: r = 8'h79; 8'h1A: r = 8'h7A;
      8'h16: r = shift ? 8'h21 : 8'h31;
      8'h1E: r = shift ? 8'h40 : 8'h32;
      8'h26: r = shift ? 8'h23 : 8'h33;
      8'h25: r = shift ? 8'h24 : 8'h34;
      8'h2E: r = shift ? 8'h25 : 8'h35;
      8'h36: r = shift ? 8'h5E : 8'h36;
      8'h3D: r = shift ? 8'h26 : 8'h37;
      8'h3E: r = shift ? 8'h2A : 8'h38;
      8'h46: r = shift ? 8'h28 : 8'h39;
      8'h45: r = shift ? 8'h29 : 8'h30;
      8'h4E: r = shift ? 8'h5F : 8'h2D;
      8'h55: r = shift ? 8'h2B : 8'h3D;
      8'h54: r = shift ? 8'h7B : 8'h5B;
      8'h5B: r = shift ? 8'h7D : 8'h5D;
      8'h5D: r = shift ? 8'h7C : 8'h5C;
      8'h4C: r = shift ? 8'h3A : 8'h3B;
      8'h52: r = shift ? 8'h22 : 8'h27;
      8'h41: r = shift ? 8'h3C : 8'h2C;
      8'h49: r = shift ? 8'h3E : 8'h2E;
      8'h4A: r = shift ? 8'h3F : 8'h2F;
      8'h0E: r = shift ? 8'h7E : 8'h60;
      8'h5A: r = 8'h0D;
      8'h66: r = 8'h08;
      8'h76: r = 8'h1B;
      8'h29: r = 8'h20;
      8'h0D: r = 8'h09;
      default: r = 8'h00;
    endcase
    if (shift && r >= 8'h61 && r <= 8'h7A) begin
      r = r - 8'h20;
    end
    return r;
  endfunction

  function automatic logic [7:0] ext_lookup(input logic [7:0] code);
    logic [7:0] r;
    case (code)
      8'h75:   r = 8'h01;
      8'h72:   r = 8'h02;
      8'h6B:   r = 8'h03;
      8'h74:   r = 8'h04;
      8'h5A:   r = 8'h0D;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign w_dat  = r_dat_sync[1];
  assign w_norm = norm_lookup(r_shreg, r_shift);
  assign w_extc = ext_lookup(r_shreg);
`ifdef PS2_PARITY_EN
  assign w_par_ok = ^{r_shreg, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_filt <= 1'b1;
      r_fcnt     <= '0;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_dat};
      r_fall     <= 1'b0;
      if (r_clk_sync[1] == r_clk_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER - 1)) begin
        r_clk_filt <= r_clk_sync[1];
        r_fcnt     <= '0;
        r_fall     <= r_clk_filt;
      end else begin
        r_fcnt <= r_fcnt + FW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    kdone <= 1'b0;
    if (reset) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_timer  <= '0;
      r_shift  <= 1'b0;
      r_brk    <= 1'b0;
      r_ext    <= 1'b0;
      ascii    <= '0;
`ifdef PS2_PARITY_EN
      r_par    <= 1'b0;
`endif
    end else begin
      if (r_state != S_IDLE && !r_fall) begin
        if (r_timer >= TW'(TIMEOUT - 1)) begin
          r_state <= S_IDLE;
          r_timer <= '0;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end else begin
        r_timer <= '0;
      end

      if (r_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!w_dat) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end
          end
          S_DATA: begin
            r_shreg  <= {w_dat, r_shreg[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
`ifdef PS2_PARITY_EN
            r_par   <= w_dat;
`endif
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (w_dat && w_par_ok) begin
              if (r_shreg == 8'hE0) begin
                r_ext <= 1'b1;
              end else if (r_shreg == 8'hF0) begin
                r_brk <= 1'b1;
              end else begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
                if (r_shreg == 8'h12 || r_shreg == 8'h59) begin
                  r_shift <= !r_brk;
                end else if (!r_brk) begin
                  if (r_ext) begin
                    if (w_extc != 8'h00) begin
                      kdone <= 1'b1;
                      ascii <= w_extc;
                    end
                  end else if (w_norm != 8'h00) begin
                    kdone <= 1'b1;
                    ascii <= w_norm;
                  end
                end
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
